// File: rtl/egress_arbiter.sv
// egress_arbiter: round-robin arbiter that moves whole frames from NUM_SRC
// ingress sources onto the shared egress FIFO write bus. A source is granted
// only when every port in its destination mask reports space. Frames longer
// than MAX_BEATS are cut short and flagged on trunc_err.
// Optional build macro: EGRESS_ARB_COUNTERS_EN adds src_frame_count.
module egress_arbiter #(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned NUM_PORTS = 15,
  parameter int unsigned MAX_BEATS = 96
) (
  input  logic                         clk_ram_ctl,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           src_req,
  input  logic [NUM_SRC*NUM_PORTS-1:0] src_port_mask,
  input  logic [NUM_SRC*11-1:0]        src_len,
  output logic [NUM_SRC-1:0]           src_grant,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC-1:0]           src_last,
  input  logic [NUM_SRC*128-1:0]       src_data,
  output logic                         frame_valid,
  output logic                         frame_last,
  output logic [127:0]                 frame_data,
  output logic [10:0]                  frame_len,
  output logic [NUM_PORTS-1:0]         frame_port_wr,
  input  logic [NUM_PORTS-1:0]         port_space_avail,
  output logic                         trunc_err
`ifdef EGRESS_ARB_COUNTERS_EN
  ,
  output logic [NUM_SRC*32-1:0]        src_frame_count
`endif
);

  localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, FORWARD, DRAIN, HOLDOFF} state_t;

  state_t                 state, state_nxt;
  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       gidx;
  logic [NUM_PORTS-1:0]   lat_mask;
  logic [10:0]            lat_len;
  logic [CNT_W-1:0]       beat_cnt;
  logic                   hold_cnt;

  logic [NUM_SRC-1:0]     eligible;
  logic                   pick_found;
  logic [PTR_W-1:0]       pick_idx;

  logic                   g_valid;
  logic                   g_last;
  logic [127:0]           g_data;

  logic                   take_grant;
  logic                   emit;
  logic                   emit_last;
  logic                   emit_trunc;
  logic                   drain_end;

  // Source eligibility: request pending and no destination port is full
  always_comb begin
    eligible = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      eligible[s] = src_req[s] &&
        ((src_port_mask[s*NUM_PORTS +: NUM_PORTS] & ~port_space_avail) == '0);
    end
  end

  // Round-robin search starting just above rr_ptr, wrapping at NUM_SRC
  always_comb begin
    int unsigned cand;
    logic [PTR_W-1:0] cand_idx;
    cand       = 0;
    cand_idx   = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      cand_idx = PTR_W'(cand);
      if (!pick_found && eligible[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign g_valid = src_valid[gidx];
  assign g_last  = src_last[gidx];
  assign g_data  = src_data[32'(gidx)*128 +: 128];

  // State register
  always_ff @(posedge clk_ram_ctl) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_found) state_nxt = FORWARD;
      FORWARD: if (g_valid) begin
                 if (g_last) state_nxt = HOLDOFF;
                 else if (beat_cnt == CNT_W'(MAX_BEATS - 1)) state_nxt = DRAIN;
               end
      DRAIN:   if (g_valid && g_last) state_nxt = HOLDOFF;
      HOLDOFF: if (hold_cnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state decode driving the registered datapath
  always_comb begin
    take_grant = 1'b0;
    emit       = 1'b0;
    emit_last  = 1'b0;
    emit_trunc = 1'b0;
    drain_end  = 1'b0;
    unique case (state)
      IDLE:    take_grant = pick_found;
      FORWARD: if (g_valid) begin
                 emit = 1'b1;
                 if (g_last) emit_last = 1'b1;
                 else if (beat_cnt == CNT_W'(MAX_BEATS - 1)) emit_trunc = 1'b1;
               end
      DRAIN:   drain_end = g_valid && g_last;
      default: ;
    endcase
  end

  // Registered outputs, grant latch, beat and holdoff counters, rr pointer
  always_ff @(posedge clk_ram_ctl) begin
    if (rst) begin
      src_grant     <= '0;
      frame_valid   <= 1'b0;
      frame_last    <= 1'b0;
      frame_data    <= '0;
      frame_len     <= '0;
      frame_port_wr <= '0;
      trunc_err     <= 1'b0;
      rr_ptr        <= PTR_W'(NUM_SRC - 1);
      gidx          <= '0;
      lat_mask      <= '0;
      lat_len       <= '0;
      beat_cnt      <= '0;
      hold_cnt      <= 1'b0;
    end else begin
      src_grant     <= '0;
      frame_valid   <= emit;
      frame_last    <= emit_last | emit_trunc;
      frame_data    <= emit ? g_data : '0;
      frame_len     <= emit_last ? lat_len : '0;
      frame_port_wr <= emit ? lat_mask : '0;
      trunc_err     <= emit_trunc;
      hold_cnt      <= (state == HOLDOFF) ? ~hold_cnt : 1'b0;
      if (take_grant) begin
        src_grant <= NUM_SRC'(1) << pick_idx;
        gidx      <= pick_idx;
        lat_mask  <= src_port_mask[32'(pick_idx)*NUM_PORTS +: NUM_PORTS];
        lat_len   <= src_len[32'(pick_idx)*11 +: 11];
        beat_cnt  <= '0;
      end else if (emit) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (emit_last || drain_end) rr_ptr <= gidx;
    end
  end

`ifdef EGRESS_ARB_COUNTERS_EN
  // Per-source count of frames that finished on their own src_last
  always_ff @(posedge clk_ram_ctl) begin
    if (rst) begin
      src_frame_count <= '0;
    end else if (emit_last) begin
      src_frame_count[32'(gidx)*32 +: 32] <= src_frame_count[32'(gidx)*32 +: 32] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_egress_arbiter.sv
// tb_egress_arbiter: table of single-frame vectors plus hand-written
// sequences for round-robin order, full-port skipping and mid-frame reset.
// Expected output beats go into a scoreboard queue as beats are driven.
module tb_egress_arbiter;
  localparam int NS = 4;
  localparam int NP = 15;
  localparam int MB = 96;

  logic              clk_ram_ctl = 1'b0;
  logic              rst;
  logic [NS-1:0]     src_req;
  logic [NS*NP-1:0]  src_port_mask;
  logic [NS*11-1:0]  src_len;
  logic [NS-1:0]     src_grant;
  logic [NS-1:0]     src_valid;
  logic [NS-1:0]     src_last;
  logic [NS*128-1:0] src_data;
  logic              frame_valid;
  logic              frame_last;
  logic [127:0]      frame_data;
  logic [10:0]       frame_len;
  logic [NP-1:0]     frame_port_wr;
  logic [NP-1:0]     port_space_avail;
  logic              trunc_err;
`ifdef EGRESS_ARB_COUNTERS_EN
  logic [NS*32-1:0]  src_frame_count;
`endif

  egress_arbiter #(.NUM_SRC(NS), .NUM_PORTS(NP), .MAX_BEATS(MB)) dut (
    .clk_ram_ctl      (clk_ram_ctl),
    .rst              (rst),
    .src_req          (src_req),
    .src_port_mask    (src_port_mask),
    .src_len          (src_len),
    .src_grant        (src_grant),
    .src_valid        (src_valid),
    .src_last         (src_last),
    .src_data         (src_data),
    .frame_valid      (frame_valid),
    .frame_last       (frame_last),
    .frame_data       (frame_data),
    .frame_len        (frame_len),
    .frame_port_wr    (frame_port_wr),
    .port_space_avail (port_space_avail),
    .trunc_err        (trunc_err)
`ifdef EGRESS_ARB_COUNTERS_EN
    ,
    .src_frame_count  (src_frame_count)
`endif
  );

  always #5 clk_ram_ctl = ~clk_ram_ctl;

  int cyc = 0;
  always @(posedge clk_ram_ctl) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [127:0]  data;
    logic          last;
    logic [10:0]   len;
    logic [NP-1:0] port;
    logic          trunc;
    int            cyc;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    int            src;
    logic [NP-1:0] mask;
    logic [10:0]   len;
    int            beats;
    int            out_beats;
    logic          trunc;
  } vec_t;

  // Output monitor: every frame_valid beat must match the scoreboard head
  always @(negedge clk_ram_ctl) begin
    exp_t e;
    if (frame_valid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat cyc=%0d got data=%h last=%b, expected no beat", cyc, frame_data, frame_last);
      end else begin
        e = sb.pop_front();
        if (frame_data !== e.data || frame_last !== e.last || frame_len !== e.len ||
            frame_port_wr !== e.port || trunc_err !== e.trunc || cyc != e.cyc + 1) begin
          fails++;
          $display("FAIL beat cyc=%0d got data=%h last=%b len=%0d port=%h trunc=%b, expected data=%h last=%b len=%0d port=%h trunc=%b cyc=%0d",
                   cyc, frame_data, frame_last, frame_len, frame_port_wr, trunc_err,
                   e.data, e.last, e.len, e.port, e.trunc, e.cyc + 1);
        end
      end
    end else begin
      tests++;
      if (frame_last !== 1'b0 || trunc_err !== 1'b0 || frame_len !== '0 || frame_port_wr !== '0) begin
        fails++;
        $display("FAIL idle_outputs cyc=%0d got last=%b trunc=%b len=%0d port=%h, expected all 0",
                 cyc, frame_last, trunc_err, frame_len, frame_port_wr);
      end
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic set_req(input int s, input logic [NP-1:0] m, input logic [10:0] l);
    src_req[s] = 1'b1;
    src_port_mask[s*NP +: NP] = m;
    src_len[s*11 +: 11] = l;
  endtask

  task automatic wait_grant(input int s, output int gcyc);
    int n;
    logic [NS-1:0] want;
    n = 0;
    want = '0;
    want[s] = 1'b1;
    while (src_grant == '0 && n < 30) begin
      @(posedge clk_ram_ctl); #1;
      n++;
    end
    gcyc = cyc;
    tests++;
    if (src_grant !== want) begin
      fails++;
      $display("FAIL grant_src%0d cyc=%0d got %b, expected %b", s, cyc, src_grant, want);
    end
  endtask

  // One beat on source s; a neighbouring source sends junk that must be ignored
  task automatic beat(input int s, input logic lst, input logic emit, input logic e_last,
                      input logic [10:0] e_len, input logic [NP-1:0] e_port, input logic e_trunc);
    exp_t e;
    int o;
    o = (s + 1) % NS;
    src_valid = '0;
    src_last  = '0;
    src_valid[s] = 1'b1;
    src_last[s]  = lst;
    src_data[s*128 +: 128] = rnd128();
    src_valid[o] = 1'b1;
    src_last[o]  = 1'b1;
    src_data[o*128 +: 128] = rnd128();
    if (emit) begin
      e.data  = src_data[s*128 +: 128];
      e.last  = e_last;
      e.len   = e_len;
      e.port  = e_port;
      e.trunc = e_trunc;
      e.cyc   = cyc;
      sb.push_back(e);
    end
    @(posedge clk_ram_ctl); #1;
    src_valid = '0;
    src_last  = '0;
  endtask

  task automatic run_vec(input vec_t v);
    int g;
    logic em;
    set_req(v.src, v.mask, v.len);
    wait_grant(v.src, g);
    src_req[v.src] = 1'b0;
    for (int b = 0; b < v.beats; b++) begin
      em = (b < v.out_beats);
      beat(v.src, b == v.beats - 1, em, em && (b == v.out_beats - 1),
           (em && b == v.beats - 1) ? v.len : 11'd0, v.mask,
           v.trunc && (b == v.out_beats - 1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int g0, g2, c_after, got_grant;

    vecs[0] = '{src: 1, mask: 15'h0001, len: 11'd64,   beats: 4,   out_beats: 4,  trunc: 1'b0};
    vecs[1] = '{src: 3, mask: 15'h7FFF, len: 11'd1,    beats: 1,   out_beats: 1,  trunc: 1'b0};
    vecs[2] = '{src: 0, mask: 15'h0000, len: 11'd100,  beats: 3,   out_beats: 3,  trunc: 1'b0};
    vecs[3] = '{src: 2, mask: 15'h4002, len: 11'd1536, beats: 100, out_beats: MB, trunc: 1'b1};
    vecs[4] = '{src: 1, mask: 15'h0010, len: 11'd1536, beats: MB,  out_beats: MB, trunc: 1'b0};

    rst = 1'b1;
    src_req = '0;
    src_port_mask = '0;
    src_len = '0;
    src_valid = '0;
    src_last = '0;
    src_data = '0;
    port_space_avail = '1;
    repeat (3) @(posedge clk_ram_ctl);
    #1;
    tests++;
    if ({src_grant, frame_valid, frame_last, frame_data, frame_len, frame_port_wr, trunc_err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got grant=%b valid=%b last=%b data=%h len=%0d port=%h trunc=%b, expected all 0",
               src_grant, frame_valid, frame_last, frame_data, frame_len, frame_port_wr, trunc_err);
    end
    rst = 1'b0;

    // Sources 0 and 2 together from rr_ptr=3: 0 first, 2 after the holdoff
    set_req(0, 15'h0001, 11'd16);
    set_req(2, 15'h0001, 11'd32);
    wait_grant(0, g0);
    src_req[0] = 1'b0;
    beat(0, 1'b1, 1'b1, 1'b1, 11'd16, 15'h0001, 1'b0);
    c_after = cyc;
    wait_grant(2, g2);
    src_req[2] = 1'b0;
    tests++;
    if (g2 != c_after + 3) begin
      fails++;
      $display("FAIL holdoff_gap got grant at cyc %0d, expected cyc %0d", g2, c_after + 3);
    end
    beat(2, 1'b1, 1'b1, 1'b1, 11'd32, 15'h0001, 1'b0);

    // Move rr_ptr to 0 so source 1 is next in order, then block its port 2
    set_req(0, 15'h0001, 11'd8);
    wait_grant(0, g0);
    src_req[0] = 1'b0;
    beat(0, 1'b1, 1'b1, 1'b1, 11'd8, 15'h0001, 1'b0);
    port_space_avail[2] = 1'b0;
    set_req(1, 15'h0006, 11'd10);
    set_req(3, 15'h0001, 11'd20);
    wait_grant(3, g0);
    src_req[3] = 1'b0;
    beat(3, 1'b1, 1'b1, 1'b1, 11'd20, 15'h0001, 1'b0);
    got_grant = 0;
    repeat (6) begin
      @(posedge clk_ram_ctl); #1;
      if (src_grant != '0) got_grant++;
    end
    tests++;
    if (got_grant != 0) begin
      fails++;
      $display("FAIL blocked_no_grant got %0d grant cycles, expected 0", got_grant);
    end
    port_space_avail[2] = 1'b1;
    wait_grant(1, g0);
    src_req[1] = 1'b0;
    beat(1, 1'b1, 1'b1, 1'b1, 11'd10, 15'h0006, 1'b0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset on beat 3: frame abandoned, rr_ptr back to NUM_SRC-1
    set_req(2, 15'h0100, 11'd128);
    wait_grant(2, g0);
    src_req[2] = 1'b0;
    beat(2, 1'b0, 1'b1, 1'b0, 11'd0, 15'h0100, 1'b0);
    beat(2, 1'b0, 1'b1, 1'b0, 11'd0, 15'h0100, 1'b0);
    src_valid[2] = 1'b1;
    src_data[2*128 +: 128] = rnd128();
    rst = 1'b1;
    @(posedge clk_ram_ctl); #1;
    tests++;
    if ({src_grant, frame_valid, frame_last, frame_data, frame_len, frame_port_wr, trunc_err} !== '0) begin
      fails++;
      $display("FAIL midframe_reset got grant=%b valid=%b last=%b len=%0d port=%h trunc=%b, expected all 0",
               src_grant, frame_valid, frame_last, frame_len, frame_port_wr, trunc_err);
    end
    rst = 1'b0;
    src_valid = '0;
    set_req(0, 15'h0001, 11'd1);
    set_req(1, 15'h0001, 11'd2);
    set_req(3, 15'h0001, 11'd3);
    wait_grant(0, g0);
    src_req[0] = 1'b0;
    beat(0, 1'b1, 1'b1, 1'b1, 11'd1, 15'h0001, 1'b0);
    wait_grant(1, g0);
    src_req[1] = 1'b0;
    beat(1, 1'b1, 1'b1, 1'b1, 11'd2, 15'h0001, 1'b0);
    wait_grant(3, g0);
    src_req[3] = 1'b0;
    beat(3, 1'b1, 1'b1, 1'b1, 11'd3, 15'h0001, 1'b0);

    repeat (6) @(posedge clk_ram_ctl);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_empty got %0d pending beats, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
